// File: rtl/ps2_tx_port.sv
// ----------------------------------------------------------------------------
// ps2_tx_port : FIFO-buffered PS/2 device-to-host byte transmitter with inhibit abort
// Revision    : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ps2_tx_port #(
  parameter int FIFO_BITS   = 3,
  parameter int HALF_PERIOD = 2000
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 wr,
  input  logic [7:0]           wr_data,
  input  logic                 ovf_clr,
  input  logic                 ps2_clk_in,
  output logic                 ps2_clk_out,
  output logic                 ps2_data_out,
  output logic                 full,
  output logic                 empty,
  output logic [FIFO_BITS:0]   level,
  output logic                 overflow,
  output logic                 busy
);

  localparam int          DEPTH     = 2 ** FIFO_BITS;
  localparam logic [15:0] C_HP_LAST = 16'(HALF_PERIOD - 1);
  localparam logic [3:0]  C_IDX_STOP = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BIT  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic                 phb_q, phb_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [10:0]          frame_q, frame_d;

  logic [7:0]           mem_q [DEPTH];
  logic [FIFO_BITS:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_BITS:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_BITS:0]   level_q, level_d;
  logic                 full_q, empty_q, ovf_q, ovf_d;

  logic                 w_pop;
  logic                 w_push;
  logic [7:0]           w_head;

  assign w_head = mem_q[rd_ptr_q[FIFO_BITS-1:0]];

  // A full FIFO still accepts a write when the transmitter frees a slot that cycle.
  assign w_push   = wr && (!full_q || w_pop);
  assign wr_ptr_d = wr_ptr_q + {{FIFO_BITS{1'b0}}, w_push};
  assign rd_ptr_d = rd_ptr_q + {{FIFO_BITS{1'b0}}, w_pop};
  assign level_d  = wr_ptr_d - rd_ptr_d;
  assign ovf_d    = (wr && full_q && !w_pop) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= level_d[FIFO_BITS];
      empty_q  <= (level_d == '0);
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_push && !reset) begin
      mem_q[wr_ptr_q[FIFO_BITS-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      phb_q   <= 1'b0;
      cnt_q   <= 16'd0;
      frame_q <= 11'h7FF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phb_q   <= phb_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phb_d   = phb_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    w_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_q && ps2_clk_in) begin
          state_d = S_BIT;
          idx_d   = 4'd0;
          phb_d   = 1'b0;
          cnt_d   = C_HP_LAST;
          frame_d = {1'b1, ~^w_head, w_head, 1'b0};
        end
      end
      S_BIT: begin
        // Host inhibit is only honoured at the opening of phase A for D0..parity.
        if (!phb_q && (cnt_q == C_HP_LAST) && (idx_q >= 4'd1) && (idx_q <= 4'd9) && !ps2_clk_in) begin
          state_d = S_GAP;
          cnt_d   = C_HP_LAST;
        end else if (cnt_q == 16'd0) begin
          cnt_d = C_HP_LAST;
          if (!phb_q) begin
            phb_d = 1'b1;
          end else if (idx_q == C_IDX_STOP) begin
            w_pop   = 1'b1;
            state_d = S_GAP;
          end else begin
            phb_d   = 1'b0;
            idx_d   = idx_q + 4'd1;
            frame_d = {1'b1, frame_q[10:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy         = (state_q == S_BIT);
  assign ps2_clk_out  = !((state_q == S_BIT) && phb_q);
  assign ps2_data_out = (state_q == S_BIT) ? frame_q[0] : 1'b1;
  assign full         = full_q;
  assign empty        = empty_q;
  assign level        = level_q;
  assign overflow     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_tx_port.sv
// ----------------------------------------------------------------------------
// tb_ps2_tx_port : scoreboard bench decoding PS/2 frames from ps2_tx_port
// Revision       : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_tx_port;
  localparam int FB = 3;
  localparam int HP = 4;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          wr = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          ovf_clr = 1'b0;
  logic          ps2_clk_in = 1'b1;
  logic          ps2_clk_out, ps2_data_out, full, empty, overflow, busy;
  logic [FB:0]   level;

  always #5 clk_sys = ~clk_sys;

  ps2_tx_port #(.FIFO_BITS(FB), .HALF_PERIOD(HP)) dut (
    .clk_sys(clk_sys), .reset(reset), .wr(wr), .wr_data(wr_data), .ovf_clr(ovf_clr),
    .ps2_clk_in(ps2_clk_in), .ps2_clk_out(ps2_clk_out), .ps2_data_out(ps2_data_out),
    .full(full), .empty(empty), .level(level), .overflow(overflow), .busy(busy)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_partial = 0;
  bit          mon_en = 1'b0;
  logic [10:0] sb [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected frame with hand-computed parity: {stop, parity, D7..D0, start}.
  function automatic logic [10:0] frm(input logic [7:0] b, input logic par);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Monitor: decode the line at each falling PS/2 clock, retire frames on busy fall.
  logic        m_prev_clk = 1'b1;
  logic        m_prev_busy = 1'b0;
  int          m_low = 0;
  int          m_bits = 0;
  int          m_busy = 0;
  logic [10:0] m_cap = '0;

  always @(negedge clk_sys) begin
    if (busy === 1'b1) m_busy++;
    if (m_prev_clk && ps2_clk_out === 1'b0) begin
      if (m_bits < 11) m_cap[m_bits] = ps2_data_out;
      m_bits++;
    end
    if (ps2_clk_out === 1'b0) m_low++;
    else if (!m_prev_clk) begin
      check("clk_low_width", m_low, HP);
      m_low = 0;
    end
    if (mon_en && busy === 1'b0) check("idle_lines", {ps2_clk_out, ps2_data_out}, 2'b11);
    if (m_prev_busy && busy === 1'b0) begin
      if (m_bits == 11) begin
        if (sb.size() == 0) check("frame_expected", sb.size(), 1);
        else check("frame", m_cap, sb.pop_front());
        check("frame_len", m_busy, 22 * HP);
      end else begin
        n_partial++;
      end
      m_bits = 0;
      m_busy = 0;
    end
    m_prev_clk  = (ps2_clk_out !== 1'b0);
    m_prev_busy = (busy === 1'b1);
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_wr(input logic [7:0] b);
    wr = 1'b1;
    wr_data = b;
    tick();
    wr = 1'b0;
  endtask

  task automatic do_clr();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  task automatic wait_busy(input logic want, input int budget);
    bit hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      tick();
      if (busy === want) hit = 1'b1;
    end
    if (!hit) check("wait_busy_timeout", busy, want);
  endtask

  task automatic drain();
    bit hit = 1'b0;
    for (int k = 0; k < 4000 && !hit; k++) begin
      tick();
      if (empty === 1'b1 && busy === 1'b0) hit = 1'b1;
    end
    check("drain", {empty, busy}, 2'b10);
    repeat (2 * HP) tick();
  endtask

  logic par_tab [1:8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic par_hi  [1:8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    // Reset with a write strobe that must be ignored.
    wr = 1'b1;
    wr_data = 8'hEE;
    repeat (3) tick();
    reset = 1'b0;
    wr = 1'b0;
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_lines", {ps2_clk_out, ps2_data_out}, 2'b11);
    tick();
    check("rst_wr_ignored", empty, 1);
    mon_en = 1'b1;

    // Single byte A5.
    sb.push_back(frm(8'hA5, 1'b1));
    do_wr(8'hA5);
    check("a5_level_wr", level, 1);
    wait_busy(1'b1, 20);
    check("a5_level_mid", level, 1);
    wait_busy(1'b0, 200);
    check("a5_level_end", level, 0);
    drain();

    // Parity corners.
    sb.push_back(frm(8'h00, 1'b1));
    sb.push_back(frm(8'hFF, 1'b1));
    sb.push_back(frm(8'h01, 1'b0));
    do_wr(8'h00);
    do_wr(8'hFF);
    do_wr(8'h01);
    drain();

    // Fill while inhibited, overflow, clear priority, then release.
    ps2_clk_in = 1'b0;
    for (int b = 1; b <= 9; b++) begin
      if (b <= 8) sb.push_back(frm(8'(b), par_tab[b]));
      do_wr(8'(b));
      if (b == 8) begin
        check("fill_level8", level, 8);
        check("fill_full8", full, 1);
        check("fill_ovf8", overflow, 0);
      end
    end
    check("ovf_level", level, 8);
    check("ovf_full", full, 1);
    check("ovf_set", overflow, 1);
    do_clr();
    check("ovf_clr", overflow, 0);
    wr = 1'b1;
    wr_data = 8'hAA;
    ovf_clr = 1'b1;
    tick();
    wr = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_priority", overflow, 1);
    check("ovf_level_kept", level, 8);
    do_clr();
    check("ovf_clr2", overflow, 0);
    ps2_clk_in = 1'b1;
    drain();

    // Write on the exact pop cycle of a full FIFO.
    ps2_clk_in = 1'b0;
    for (int b = 1; b <= 8; b++) begin
      sb.push_back(frm(8'(8'h10 + b), par_hi[b]));
      do_wr(8'(8'h10 + b));
    end
    ps2_clk_in = 1'b1;
    wait_busy(1'b1, 20);
    repeat (87) tick();
    check("pop_busy_last", busy, 1);
    sb.push_back(frm(8'h19, 1'b0));
    wr = 1'b1;
    wr_data = 8'h19;
    tick();
    wr = 1'b0;
    check("pop_wr_level", level, 8);
    check("pop_wr_full", full, 1);
    check("pop_wr_ovf", overflow, 0);
    check("pop_wr_busy", busy, 0);
    drain();

    // Inhibit at D3 phase A of 3C, then full resend.
    sb.push_back(frm(8'h3C, 1'b1));
    do_wr(8'h3C);
    wait_busy(1'b1, 20);
    repeat (32) tick();
    check("abort_pre_busy", busy, 1);
    check("abort_d3_bit", ps2_data_out, 1);
    ps2_clk_in = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_lines", {ps2_clk_out, ps2_data_out}, 2'b11);
    check("abort_level", level, 1);
    repeat (10) tick();
    check("abort_hold", busy, 0);
    ps2_clk_in = 1'b1;
    drain();

    // Reset during the parity bit discards everything.
    ps2_clk_in = 1'b0;
    do_wr(8'h5A);
    do_wr(8'h77);
    ps2_clk_in = 1'b1;
    wait_busy(1'b1, 20);
    repeat (72) tick();
    check("rst_par_bit", ps2_data_out, 1);
    reset = 1'b1;
    tick();
    check("midrst_lines", {ps2_clk_out, ps2_data_out}, 2'b11);
    check("midrst_level", level, 0);
    check("midrst_busy", busy, 0);
    check("midrst_empty", empty, 1);
    reset = 1'b0;
    repeat (300) tick();
    check("midrst_quiet", busy, 0);

    check("sb_empty", sb.size(), 0);
    check("partials", n_partial, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/ps2_tx_port.md
PS2_TX_PORT -- requirements
Module: ps2_tx_port

Interface
REQ-001 SHALL have parameter FIFO_BITS, default 3, meaning log2 of FIFO depth (depth = 2**FIFO_BITS bytes).
REQ-002 SHALL have parameter HALF_PERIOD, default 2000, meaning clk_sys cycles per PS/2 clock half-period (legal range 2..65535).
REQ-003 SHALL have port clk_sys  in  1  system clock; this is the only clock, and all logic is rising-edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port wr  in  1  one-cycle write strobe for wr_data.
REQ-006 SHALL have port wr_data  in  8  byte to queue.
REQ-007 SHALL have port ovf_clr  in  1  clears overflow.
REQ-008 SHALL have port ps2_clk_in  in  1  sensed PS/2 clock line (host inhibit detection).
REQ-009 SHALL have port ps2_clk_out  out  1  generated PS/2 clock (1 = released/high).
REQ-010 SHALL have port ps2_data_out  out  1  PS/2 data (1 = released/high).
REQ-011 SHALL have port full  out  1  FIFO full.
REQ-012 SHALL have port empty  out  1  FIFO empty.
REQ-013 SHALL have port level  out  FIFO_BITS+1  bytes held in the FIFO.
REQ-014 SHALL have port overflow  out  1  sticky flag for a dropped write.
REQ-015 SHALL have port busy  out  1  frame in progress.

Function
REQ-016 SHALL implement FIFO storage with registered full, empty and level derived from write/read pointers one bit wider than FIFO_BITS, so wrap-around is exact.
REQ-017 SHALL accept wr when not full, or when full and a pop occurs in the same cycle; in that case level stays unchanged.
REQ-018 SHALL drop wr when full without a same-cycle pop, set overflow, and leave FIFO contents unchanged.
REQ-019 SHALL give overflow priority over ovf_clr when both occur in the same cycle.
REQ-020 SHALL implement an FSM with states IDLE, BIT and GAP; bit index 0..10 covers start, D0..D7 (LSB first), odd parity and stop.
REQ-021 SHALL leave IDLE for BIT (index 0) on the cycle after it observes ~empty & ps2_clk_in=1; the head byte is latched into a shift register and is not popped.
REQ-022 SHALL divide each bit into two phases: phase A holds ps2_clk_out=1 and drives ps2_data_out=bit value for HALF_PERIOD cycles; phase B drives ps2_clk_out=0 for HALF_PERIOD cycles with data held.
REQ-023 SHALL make the frame length exactly 22*HALF_PERIOD cycles.
REQ-024 SHALL set the parity bit to ~^(byte), which is odd parity; the start bit is 0 and the stop bit is 1.
REQ-025 SHALL pop the FIFO on the last cycle of stop-bit phase B, then enter GAP, which lasts HALF_PERIOD cycles with both lines high, then IDLE.
REQ-026 SHALL detect inhibit by sampling ps2_clk_in on the first cycle of each phase A for indices 1..9.
REQ-027 SHALL, if ps2_clk_in=0 at that sample, abort the frame: both outputs go to 1 next cycle, the FSM enters GAP, and the byte stays at the FIFO head for full retransmission.
REQ-028 SHALL ignore inhibit during the stop bit, so the frame completes normally.
REQ-029 SHALL drive busy=1 in BIT only.
REQ-030 SHALL keep ps2_clk_out=1 and ps2_data_out=1 in IDLE and GAP.
REQ-031 SHALL size the half-period counter at 16 bits, loaded with HALF_PERIOD-1 and counting down to 0.

Reset
REQ-032 SHALL, on reset, clear pointers and set level=0, empty=1, full=0, overflow=0, busy=0, ps2_clk_out=1, ps2_data_out=1, FSM=IDLE.
REQ-033 SHALL, on reset mid-frame, abandon the frame immediately; the queued data is discarded.
REQ-034 SHALL ignore wr in the reset cycle.

Verification (HALF_PERIOD=4, FIFO_BITS=3)
REQ-035 SHALL cover: single wr of 8'hA5 -> one frame of 88 cycles; data 0,1,0,1,0,0,1,0,1,1,1; 11 clock low pulses of 4 cycles; level 1->0 at stop end.
REQ-036 SHALL cover: 9 wr while ps2_clk_in=0 -> level=8, full=1, overflow=1 after 9th; ovf_clr -> overflow=0; contents 1..8 transmitted in order once ps2_clk_in=1.
REQ-037 SHALL cover: ps2_clk_in forced 0 at D3 phase A of byte 8'h3C -> outputs high next cycle, busy=0, level unchanged; on release the full 8'h3C frame is resent after a 4-cycle gap.
REQ-038 SHALL cover: full FIFO with wr on the pop cycle -> write accepted, level stays 8, overflow=0.
REQ-039 SHALL cover: reset asserted at parity bit -> next cycle both outputs 1, level=0, busy=0; no frame follows.
REQ-040 SHALL cover: 8'h00 parity bit=1; 8'hFF parity bit=1; 8'h01 parity bit=0.
